// File: rtl/basic_search_feeder.sv
// Streams reference rows and current-CU beats from on-chip buffers into the integer motion-search engine.
// Optional build macro FEEDER_STALL_EN adds a stall input that freezes issue and sequencing.
module basic_search_feeder #(
    parameter int REF_ROWS     = 96,
    parameter int PRELOAD_ROWS = 32,
    parameter int CUR_BEATS    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
`ifdef FEEDER_STALL_EN
    input  logic         stall,
`endif
    output logic         ref_rd_en,
    output logic [6:0]   ref_rd_addr,
    input  logic [255:0] ref_rd_data,
    output logic         cur_rd_en,
    output logic [3:0]   cur_rd_addr,
    input  logic [511:0] cur_rd_data,
    output logic [255:0] ref_input,
    output logic [511:0] current_64pixels,
    output logic         ref_valid,
    output logic         cur_valid,
    output logic         ref_begin_prepare,
    output logic         pe_begin_prepare,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_CURLOAD,
        S_SEARCH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [6:0] LP_PRE_LAST = 7'(PRELOAD_ROWS - 1);
    localparam logic [6:0] LP_REF_LAST = 7'(REF_ROWS - 1);
    localparam logic [3:0] LP_CUR_LAST = 4'(CUR_BEATS - 1);

    state_t        r_state;
    logic [6:0]    r_ref_addr;
    logic [3:0]    r_cur_addr;
    logic          r_drain_cnt;
    logic          r_done;
    logic          r_busy;

    logic          r_ref_vld_p0;
    logic          r_cur_vld_p0;
    logic          r_ref_vld_p1;
    logic          r_cur_vld_p1;
    logic [255:0]  r_ref_data_p1;
    logic [511:0]  r_cur_data_p1;
    logic          r_ref_prep;
    logic          r_pe_prep;

    logic          w_run;
    logic          w_ref_issue;
    logic          w_cur_issue;

`ifdef FEEDER_STALL_EN
    assign w_run = ~stall;
`else
    assign w_run = 1'b1;
`endif

    assign w_ref_issue = w_run && ((r_state == S_PRELOAD) || (r_state == S_SEARCH));
    assign w_cur_issue = w_run && (r_state == S_CURLOAD);

    assign ref_rd_en   = w_ref_issue;
    assign ref_rd_addr = r_ref_addr;
    assign cur_rd_en   = w_cur_issue;
    assign cur_rd_addr = r_cur_addr;

    // Sequencer: the reference address carries over from PRELOAD into SEARCH so rows stay contiguous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ref_addr  <= '0;
            r_cur_addr  <= '0;
            r_drain_cnt <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (r_state != S_IDLE) && (r_state != S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_PRELOAD;
                end
                S_PRELOAD: begin
                    if (w_run) begin
                        r_ref_addr <= r_ref_addr + 7'd1;
                        if (r_ref_addr == LP_PRE_LAST) r_state <= S_CURLOAD;
                    end
                end
                S_CURLOAD: begin
                    if (w_run) begin
                        if (r_cur_addr == LP_CUR_LAST) begin
                            r_cur_addr <= '0;
                            r_state    <= S_SEARCH;
                        end else begin
                            r_cur_addr <= r_cur_addr + 4'd1;
                        end
                    end
                end
                S_SEARCH: begin
                    if (w_run) begin
                        if (r_ref_addr == LP_REF_LAST) begin
                            r_ref_addr <= '0;
                            r_state    <= S_DRAIN;
                        end else begin
                            r_ref_addr <= r_ref_addr + 7'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_run) begin
                        if (r_drain_cnt) begin
                            r_drain_cnt <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_drain_cnt <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // p0: strobe delayed to match buffer read latency; p1: data captured onto the engine buses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_vld_p0  <= 1'b0;
            r_cur_vld_p0  <= 1'b0;
            r_ref_vld_p1  <= 1'b0;
            r_cur_vld_p1  <= 1'b0;
            r_ref_data_p1 <= '0;
            r_cur_data_p1 <= '0;
            r_ref_prep    <= 1'b0;
            r_pe_prep     <= 1'b0;
        end else begin
            r_ref_vld_p0 <= w_ref_issue;
            r_cur_vld_p0 <= w_cur_issue;
            r_ref_vld_p1 <= r_ref_vld_p0;
            r_cur_vld_p1 <= r_cur_vld_p0;
            if (r_ref_vld_p0) r_ref_data_p1 <= ref_rd_data;
            if (r_cur_vld_p0) r_cur_data_p1 <= cur_rd_data;
            if (r_done)            r_ref_prep <= 1'b0;
            else if (r_ref_vld_p0) r_ref_prep <= 1'b1;
            if (r_done)            r_pe_prep  <= 1'b0;
            else if (r_cur_vld_p0) r_pe_prep  <= 1'b1;
        end
    end

    assign ref_input         = r_ref_data_p1;
    assign current_64pixels  = r_cur_data_p1;
    assign ref_valid         = r_ref_vld_p1;
    assign cur_valid         = r_cur_vld_p1;
    assign ref_begin_prepare = r_ref_prep;
    assign pe_begin_prepare  = r_pe_prep;
    assign busy              = r_busy;
    assign done              = r_done;

endmodule
